des_region_scheduler: RTL and testbench
=======================================

# des_region_scheduler

Sequencer that sits directly upstream of the DES block wrapper and drives its command port. It hands out a contiguous range of key-space regions one at a time. For each region it runs the load-region, start, wait-for-done and restart command sequence. It collects each region's 64-bit match counter and keeps a saturating grand total for the CPU, so a whole range can be swept without software in the loop.

## Interface
Parameters:
- N, 32: region width in bits, at most 32; region bits above N are driven 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a sweep; ignored while busy.
- abort  in  1  one-cycle pulse that requests the sweep stop at the next safe point.
- first_region  in  32  first region of the sweep; sampled on start.
- last_region  in  32  last region of the sweep, inclusive; sampled on start.
- cmd  out  32  command to the wrapper: 0 = read region, 1 = start, 3 = restart.
- cmd_valid  out  1  command valid; held until cmd_read is seen high.
- region  out  32  region value presented with the read-region command.
- cmd_read  in  1  wrapper acknowledge.
- done  in  1  wrapper has finished the current region; counter is valid.
- counter  in  64  wrapper match counter.
- busy  out  1  a sweep is in progress.
- result_valid  out  1  one-cycle pulse per completed region.
- result_region  out  32  region belonging to result_count.
- result_count  out  64  that region's counter value.
- total_count  out  64  saturating sum of all result_count values in the current sweep.
- finished  out  1  one-cycle pulse when the sweep ends normally.
- aborted  out  1  one-cycle pulse when the sweep ends on abort.
- range_err  out  1  sticky flag: a start arrived with last_region < first_region; cleared by the next accepted start.

## Operation
- All outputs are registered (Moore); every output resets to 0.
- The FSM states are IDLE, LOAD_REQ, LOAD_REL, START_REQ, START_REL, RUN, COLLECT, RST_REQ, RST_REL and NEXT.
- IDLE:
  - start with last_region >= first_region: latch both bounds, set cur = first_region, clear total_count, go to LOAD_REQ.
  - start with last_region < first_region: set range_err, pulse finished, stay in IDLE.
- *_REQ states drive cmd_valid=1 with the matching cmd (region = cur in LOAD_REQ). The FSM advances to *_REL on cmd_read=1.
- *_REL states drive cmd_valid=0 and wait for cmd_read=0 before advancing. This guarantees a stale acknowledge is never reused.
- Transitions out of the *_REL states:
  - LOAD_REL goes to START_REQ.
  - START_REL goes to RUN.
  - RST_REL goes to IDLE if an abort is pending, otherwise to NEXT.
- RUN waits for done=1, then goes to COLLECT.
- RUN with an abort pending goes straight to RST_REQ; nothing is collected.
- COLLECT (1 cycle):
  - result_count = counter; result_region = cur; result_valid pulses.
  - total_count += counter, saturating at 64'hFFFF_FFFF_FFFF_FFFF.
  - Go to RST_REQ.
- NEXT:
  - If cur == last_region: pulse finished, go to IDLE.
  - Otherwise cur += 1 and go to LOAD_REQ.
  - The compare happens before the increment, so last_region = 32'hFFFF_FFFF terminates without wrapping.
- Abort handling:
  - abort sets a pending flag in any non-IDLE state.
  - The flag is acted on in RUN or RST_REL only. An in-flight handshake always completes first, so the wrapper is never left with cmd_valid high.
  - The aborted pulse is issued on entry to IDLE; the flag then clears.
  - abort in IDLE is ignored.
- cur is masked to N bits on output; the first/last compare is done on the full 32 bits.
- start and abort arriving in the same IDLE cycle: the start is accepted and the abort is ignored.

## Timing
- A command handshake with the wrapper takes 4 cycles: REQ, ack seen, REL, ack-low seen.
- Per-region overhead outside RUN is 3 handshakes plus COLLECT plus NEXT, about 14 cycles.
- busy rises the cycle after an accepted start. It falls in the same cycle that finished or aborted is asserted.
- result_valid and the total_count update occur in the same cycle.
- done is sampled only in RUN; done seen while in RST_* states is ignored.
- Reset asserted mid-sweep:
  - The FSM returns to IDLE and cmd_valid drops within 1 cycle.
  - No finished or aborted pulse is issued.
  - The wrapper is reset separately.

## Structure
- The package des_pkg holds the CMD_READ_REGION, CMD_START and CMD_RESTART constants and the scheduler state enum. These are shared with the wrapper.
- One sub-module, des_cmd_port, implements the generic REQ/REL handshake: inputs issue and cmd_code; output complete.
- The saturating accumulator stays inline.

## Test plan
- Sweep first=5, last=7 against a wrapper model returning counter = region*10:
  - result_valid fires 3 times with pairs (5,50), (6,60), (7,70).
  - total_count = 180; finished pulses once.
- Sweep first=last=32'hFFFF_FFFF: exactly one region is processed, finished pulses, and cur does not wrap.
- start with first=9, last=3: range_err=1, finished pulses, busy stays 0, and cmd_valid never rises.
- Abort pulse during START_REQ of region 2 in a sweep of 0..4:
  - The handshake completes.
  - A restart command is issued with no result for region 2.
  - aborted pulses, and total_count equals the region 0+1 sum.
- counter = 64'hFFFF_FFFF_FFFF_FFF0 followed by 64'h20: total_count saturates to all-ones.
- Wrapper model holds cmd_read high for 5 extra cycles: the scheduler waits in *_REL, and each command is issued exactly once.

Source files
------------

// File: rtl/des_pkg.sv
// Shared command codes, FSM encodings and helpers for the DES region scheduler
// and the DES block wrapper it drives.
package des_pkg;

  localparam int unsigned CMD_W    = 32;
  localparam int unsigned REGION_W = 32;
  localparam int unsigned COUNT_W  = 64;

  localparam logic [CMD_W-1:0] CMD_READ_REGION = 32'd0;
  localparam logic [CMD_W-1:0] CMD_START       = 32'd1;
  localparam logic [CMD_W-1:0] CMD_RESTART     = 32'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_REQ,
    S_LOAD_REL,
    S_START_REQ,
    S_START_REL,
    S_RUN,
    S_COLLECT,
    S_RST_REQ,
    S_RST_REL,
    S_NEXT
  } sched_state_e;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_REQ,
    PORT_REL
  } port_state_e;

  typedef struct packed {
    logic [REGION_W-1:0] region;
    logic [COUNT_W-1:0]  count;
  } region_result_t;

  // Unsigned add that clamps at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] a,
                                                 input logic [COUNT_W-1:0] b);
    logic [COUNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COUNT_W] ? {COUNT_W{1'b1}} : sum[COUNT_W-1:0];
  endfunction

endpackage

// File: rtl/des_cmd_port.sv
// Generic REQ/REL command handshake: raise cmd_valid until acknowledged, then
// wait for the acknowledge to drop before reporting the command complete.
module des_cmd_port
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                issue,
  input  logic [CMD_W-1:0]    cmd_code,
  input  logic [REGION_W-1:0] arg,
  input  logic                cmd_read,
  output logic [CMD_W-1:0]    cmd,
  output logic                cmd_valid,
  output logic [REGION_W-1:0] region,
  output logic                ack_c,
  output logic                complete_c
);

  port_state_e         phase_q, phase_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [REGION_W-1:0] region_q, region_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                free_c;

  always_comb begin
    phase_d     = phase_q;
    cmd_d       = cmd_q;
    region_d    = region_q;
    cmd_valid_d = cmd_valid_q;
    ack_c       = 1'b0;
    complete_c  = 1'b0;
    free_c      = (phase_q == PORT_IDLE);
    case (phase_q)
      PORT_REQ: begin
        if (cmd_read) begin
          ack_c       = 1'b1;
          cmd_valid_d = 1'b0;
          phase_d     = PORT_REL;
        end
      end
      PORT_REL: begin
        if (!cmd_read) begin
          complete_c = 1'b1;
          phase_d    = PORT_IDLE;
          free_c     = 1'b1;
        end
      end
      default: ;
    endcase
    // A new command may start in the same cycle the previous one completes.
    if (free_c && issue) begin
      phase_d     = PORT_REQ;
      cmd_valid_d = 1'b1;
      cmd_d       = cmd_code;
      region_d    = arg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= PORT_IDLE;
      cmd_q       <= '0;
      region_q    <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      cmd_q       <= cmd_d;
      region_q    <= region_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign region    = region_q;

endmodule

// File: rtl/des_region_scheduler.sv
// Sweeps a contiguous range of key-space regions through the DES wrapper,
// collecting each region's match counter into a saturating grand total.
module des_region_scheduler
  import des_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [REGION_W-1:0] first_region,
  input  logic [REGION_W-1:0] last_region,
  output logic [CMD_W-1:0]    cmd,
  output logic                cmd_valid,
  output logic [REGION_W-1:0] region,
  input  logic                cmd_read,
  input  logic                done,
  input  logic [COUNT_W-1:0]  counter,
  output logic                busy,
  output logic                result_valid,
  output logic [REGION_W-1:0] result_region,
  output logic [COUNT_W-1:0]  result_count,
  output logic [COUNT_W-1:0]  total_count,
  output logic                finished,
  output logic                aborted,
  output logic                range_err
);

  localparam logic [REGION_W-1:0] REGION_MASK =
    (N >= REGION_W) ? 32'hFFFF_FFFF : REGION_W'((64'd1 << N) - 64'd1);

  sched_state_e        state_q, state_d;
  logic [REGION_W-1:0] cur_q, cur_d;
  logic [REGION_W-1:0] last_q, last_d;
  logic [COUNT_W-1:0]  total_q, total_d;
  region_result_t      res_q, res_d;
  logic                result_valid_q, result_valid_d;
  logic                finished_q, finished_d;
  logic                aborted_q, aborted_d;
  logic                busy_q, busy_d;
  logic                range_err_q, range_err_d;
  logic                abort_pend_q, abort_pend_d;

  logic                abort_now_c;
  logic                issue_c;
  logic [CMD_W-1:0]    issue_code_c;
  logic                ack_c;
  logic                complete_c;

  assign abort_now_c = abort_pend_q | abort;

  always_comb begin
    state_d        = state_q;
    cur_d          = cur_q;
    last_d         = last_q;
    total_d        = total_q;
    res_d          = res_q;
    result_valid_d = 1'b0;
    finished_d     = 1'b0;
    aborted_d      = 1'b0;
    range_err_d    = range_err_q;
    abort_pend_d   = abort_pend_q | ((state_q != S_IDLE) && abort);
    issue_c        = 1'b0;
    issue_code_c   = CMD_READ_REGION;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (last_region >= first_region) begin
            last_d       = last_region;
            cur_d        = first_region;
            total_d      = '0;
            range_err_d  = 1'b0;
            state_d      = S_LOAD_REQ;
            issue_c      = 1'b1;
            issue_code_c = CMD_READ_REGION;
          end else begin
            range_err_d = 1'b1;
            finished_d  = 1'b1;
          end
        end
      end
      S_LOAD_REQ:  if (ack_c) state_d = S_LOAD_REL;
      S_START_REQ: if (ack_c) state_d = S_START_REL;
      S_RST_REQ:   if (ack_c) state_d = S_RST_REL;
      S_LOAD_REL: begin
        if (complete_c) begin
          state_d      = S_START_REQ;
          issue_c      = 1'b1;
          issue_code_c = CMD_START;
        end
      end
      S_START_REL: if (complete_c) state_d = S_RUN;
      S_RUN: begin
        // An abort skips collection; the wrapper is still restarted cleanly.
        if (abort_now_c) begin
          state_d      = S_RST_REQ;
          issue_c      = 1'b1;
          issue_code_c = CMD_RESTART;
        end else if (done) begin
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        res_d.region   = cur_q & REGION_MASK;
        res_d.count    = counter;
        result_valid_d = 1'b1;
        total_d        = sat_add(total_q, counter);
        state_d        = S_RST_REQ;
        issue_c        = 1'b1;
        issue_code_c   = CMD_RESTART;
      end
      S_RST_REL: begin
        if (complete_c) begin
          if (abort_now_c) begin
            state_d      = S_IDLE;
            aborted_d    = 1'b1;
            abort_pend_d = 1'b0;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        // Compare before incrementing so an all-ones last region never wraps.
        if (cur_q == last_q) begin
          finished_d   = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          cur_d        = cur_q + 32'd1;
          state_d      = S_LOAD_REQ;
          issue_c      = 1'b1;
          issue_code_c = CMD_READ_REGION;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cur_q          <= '0;
      last_q         <= '0;
      total_q        <= '0;
      res_q          <= '0;
      result_valid_q <= 1'b0;
      finished_q     <= 1'b0;
      aborted_q      <= 1'b0;
      busy_q         <= 1'b0;
      range_err_q    <= 1'b0;
      abort_pend_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      last_q         <= last_d;
      total_q        <= total_d;
      res_q          <= res_d;
      result_valid_q <= result_valid_d;
      finished_q     <= finished_d;
      aborted_q      <= aborted_d;
      busy_q         <= busy_d;
      range_err_q    <= range_err_d;
      abort_pend_q   <= abort_pend_d;
    end
  end

  des_cmd_port u_cmd_port (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue_c),
    .cmd_code   (issue_code_c),
    .arg        (cur_d & REGION_MASK),
    .cmd_read   (cmd_read),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .region     (region),
    .ack_c      (ack_c),
    .complete_c (complete_c)
  );

  assign busy          = busy_q;
  assign result_valid  = result_valid_q;
  assign result_region = res_q.region;
  assign result_count  = res_q.count;
  assign total_count   = total_q;
  assign finished      = finished_q;
  assign aborted       = aborted_q;
  assign range_err     = range_err_q;

endmodule

// File: tb/tb_des_region_scheduler.sv
// Bench for des_region_scheduler: a behavioural DES wrapper model plus a
// range-level reference of expected results, totals and command traffic.
`timescale 1ns/1ps
module tb_des_region_scheduler;
  import des_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] first_region = '0;
  logic [31:0] last_region = '0;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic [31:0] region;
  logic        cmd_read;
  logic        done;
  logic [63:0] counter;
  logic        busy;
  logic        result_valid;
  logic [31:0] result_region;
  logic [63:0] result_count;
  logic [63:0] total_count;
  logic        finished;
  logic        aborted;
  logic        range_err;

  always #5 clk = ~clk;

  des_region_scheduler #(.N(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .first_region  (first_region),
    .last_region   (last_region),
    .cmd           (cmd),
    .cmd_valid     (cmd_valid),
    .region        (region),
    .cmd_read      (cmd_read),
    .done          (done),
    .counter       (counter),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_region (result_region),
    .result_count  (result_count),
    .total_count   (total_count),
    .finished      (finished),
    .aborted       (aborted),
    .range_err     (range_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cnt_of(input int mode, input logic [31:0] r);
    if (mode == 2) return {~r, r ^ 32'h5A5A_1234};
    return 64'(r) * 64'd10;
  endfunction

  // Wrapper model: acks each command once, optionally holding the ack high.
  int          hold_extra = 0;
  int          cnt_mode = 0;
  int          hold_cnt = 0;
  int          run_cnt = 0;
  int          tbl_idx = 0;
  logic [31:0] wr_region = '0;
  logic [63:0] cnt_tbl [2];

  always @(posedge clk) begin
    if (rst) begin
      cmd_read  <= 1'b0;
      done      <= 1'b0;
      counter   <= '0;
      hold_cnt  <= 0;
      run_cnt   <= 0;
      tbl_idx   <= 0;
      wr_region <= '0;
    end else begin
      if (start) tbl_idx <= 0;
      if (run_cnt > 0) begin
        run_cnt <= run_cnt - 1;
        if (run_cnt == 1) begin
          done    <= 1'b1;
          counter <= (cnt_mode == 1) ? cnt_tbl[tbl_idx[0]] : cnt_of(cnt_mode, wr_region);
          tbl_idx <= tbl_idx + 1;
        end
      end
      if (cmd_read) begin
        if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
        else cmd_read <= 1'b0;
      end else if (cmd_valid) begin
        cmd_read <= 1'b1;
        hold_cnt <= hold_extra;
        case (cmd)
          CMD_READ_REGION: wr_region <= region;
          CMD_START:       run_cnt <= int'($urandom_range(1, 6));
          CMD_RESTART: begin
            done    <= 1'b0;
            run_cnt <= 0;
          end
          default: ;
        endcase
      end
    end
  end

  // Observation logs, sampled away from the active edge.
  logic [95:0] res_log [$];
  logic [63:0] cmd_log [$];
  int          fin_n = 0;
  int          ab_n = 0;
  int          pulse_busy_n = 0;
  int          busy_cyc = 0;
  int          valid_cyc = 0;
  logic        valid_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (result_valid) res_log.push_back({result_region, result_count});
      if (finished) fin_n++;
      if (aborted) ab_n++;
      if ((finished || aborted) && busy) pulse_busy_n++;
      if (busy) busy_cyc++;
      if (cmd_valid) valid_cyc++;
      if (cmd_valid && !valid_prev) cmd_log.push_back({cmd, region});
    end
    valid_prev = cmd_valid;
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_sweep(input string name, input logic [31:0] f, input logic [31:0] l,
                           input int mode, input longint abort_reg, input bit abort_with_start);
    logic [95:0] exp_q [$];
    logic [63:0] exp_total;
    logic [63:0] c;
    logic [64:0] s;
    int          rb, cb, fb, ab, pb, n_touch, n_rd, n_st, n_rs;
    bit          ended, armed;
    logic [31:0] ccode, creg;

    exp_total = '0;
    for (longint r = longint'(f); r <= longint'(l); r++) begin
      if (abort_reg >= 0 && r >= abort_reg) break;
      if (mode == 1) c = cnt_tbl[int'(r - longint'(f)) % 2];
      else c = cnt_of(mode, 32'(r));
      exp_q.push_back({32'(r), c});
      s = {1'b0, exp_total} + {1'b0, c};
      exp_total = (s > 65'h0_FFFF_FFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
    end
    n_touch = (abort_reg >= 0) ? int'(abort_reg - longint'(f)) + 1
                               : int'(longint'(l) - longint'(f)) + 1;

    cnt_mode = mode;
    rb = res_log.size();
    cb = cmd_log.size();
    fb = fin_n;
    ab = ab_n;
    pb = pulse_busy_n;

    @(negedge clk);
    first_region = f;
    last_region  = l;
    start        = 1'b1;
    abort        = abort_with_start;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk({name, "_busy_rise"}, 64'(busy), 64'd1);
    chk({name, "_range_err_clr"}, 64'(range_err), 64'd0);

    ended = 1'b0;
    armed = (abort_reg >= 0);
    for (int cyc = 0; cyc < 5000 && !ended; cyc++) begin
      @(negedge clk);
      abort = 1'b0;
      if (fin_n != fb || ab_n != ab) ended = 1'b1;
      else if (armed && cmd_valid && cmd == CMD_START && region == 32'(abort_reg)) begin
        abort = 1'b1;
        armed = 1'b0;
      end
    end
    abort = 1'b0;
    chk({name, "_timeout"}, 64'(ended), 64'd1);
    repeat (3) @(negedge clk);

    chk({name, "_n_results"}, 64'(res_log.size() - rb), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && rb + i < res_log.size(); i++)
      chk({name, "_result"}, res_log[rb + i][63:0] ^ 64'(res_log[rb + i][95:64]) << 1,
          exp_q[i][63:0] ^ 64'(exp_q[i][95:64]) << 1);
    for (int i = 0; i < exp_q.size() && rb + i < res_log.size(); i++)
      chk({name, "_res_region"}, 64'(res_log[rb + i][95:64]), 64'(exp_q[i][95:64]));
    chk({name, "_total"}, total_count, exp_total);
    chk({name, "_finished"}, 64'(fin_n - fb), (abort_reg >= 0) ? 64'd0 : 64'd1);
    chk({name, "_aborted"}, 64'(ab_n - ab), (abort_reg >= 0) ? 64'd1 : 64'd0);
    chk({name, "_busy_at_pulse"}, 64'(pulse_busy_n - pb), 64'd0);

    n_rd = 0;
    n_st = 0;
    n_rs = 0;
    for (int i = cb; i < cmd_log.size(); i++) begin
      ccode = cmd_log[i][63:32];
      creg  = cmd_log[i][31:0];
      if (ccode == CMD_READ_REGION) begin
        chk({name, "_load_region"}, 64'(creg), 64'(f + 32'(n_rd)));
        n_rd++;
      end else if (ccode == CMD_START) n_st++;
      else if (ccode == CMD_RESTART) n_rs++;
      else chk({name, "_bad_cmd"}, 64'(ccode), 64'(CMD_RESTART));
    end
    chk({name, "_n_load"}, 64'(n_rd), 64'(n_touch));
    chk({name, "_n_start"}, 64'(n_st), 64'(n_touch));
    chk({name, "_n_restart"}, 64'(n_rs), 64'(n_touch));
    chk({name, "_idle_busy"}, 64'(busy), 64'd0);
    chk({name, "_idle_valid"}, 64'(cmd_valid), 64'd0);
    if (!ended) do_reset();
  endtask

  initial begin
    int          fb, ab, bc, vc;
    logic [31:0] rf, rl;

    cnt_tbl[0] = 64'hFFFF_FFFF_FFFF_FFF0;
    cnt_tbl[1] = 64'h20;
    do_reset();

    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_cmd", 64'(cmd), 64'd0);
    chk("rst_region", 64'(region), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    chk("rst_result_region", 64'(result_region), 64'd0);
    chk("rst_result_count", result_count, 64'd0);
    chk("rst_total", total_count, 64'd0);
    chk("rst_finished", 64'(finished), 64'd0);
    chk("rst_aborted", 64'(aborted), 64'd0);
    chk("rst_range_err", 64'(range_err), 64'd0);

    ab = ab_n;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_abort_ignored", 64'(ab_n - ab), 64'd0);
    chk("idle_abort_busy", 64'(busy), 64'd0);

    fb = fin_n;
    bc = busy_cyc;
    vc = valid_cyc;
    first_region = 32'd9;
    last_region  = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("range_err_set", 64'(range_err), 64'd1);
    chk("range_err_finished", 64'(fin_n - fb), 64'd1);
    chk("range_err_busy", 64'(busy_cyc - bc), 64'd0);
    chk("range_err_valid", 64'(valid_cyc - vc), 64'd0);

    run_sweep("sweep_5_7", 32'd5, 32'd7, 0, -1, 1'b1);
    run_sweep("sweep_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 1'b0);
    run_sweep("abort_r2", 32'd0, 32'd4, 0, 2, 1'b0);
    run_sweep("saturate", 32'd0, 32'd1, 1, -1, 1'b0);

    hold_extra = 5;
    run_sweep("hold_ack", 32'd3, 32'd4, 0, -1, 1'b0);
    hold_extra = 0;

    for (int k = 0; k < 4; k++) begin
      rf = $urandom_range(0, 32'hFFFF_FFF0);
      rl = rf + 32'($urandom_range(0, 3));
      run_sweep("random", rf, rl, 2, -1, 1'b0);
    end

    fb = fin_n;
    ab = ab_n;
    first_region = 32'd100;
    last_region  = 32'd120;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 64'(cmd_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_total", total_count, 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_no_finished", 64'(fin_n - fb), 64'd0);
    chk("midrst_no_aborted", 64'(ab_n - ab), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
